// File: rtl/class_mem_pkg.sv
// Shared types and constants for the banked class-hypervector memory controller.
package class_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FTWIDTH_DEF      = 8;
  localparam int NUM_BANKS_DEF    = 16;
  localparam int DEPTH_DEF        = 6500;
  localparam int TOTAL_WRITES_DEF = 104000;
  localparam int ADDR_WIDTH_DEF   = 13;

  // Rows touched by a load; a partially filled last row still counts.
  function automatic int rows_used(input int total, input int banks);
    return (total + banks - 1) / banks;
  endfunction

endpackage

// File: rtl/class_mem_bank.sv
// Single-port synchronous RAM bank. A write suppresses the read, so data_out
// only changes on an enabled read and otherwise holds its last value.
module class_mem_bank #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 6500,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [WIDTH-1:0]      data_in,
  output logic [WIDTH-1:0]      data_out
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]    idx;

  assign idx = address[IW-1:0];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= data_in;
    end else if (en) begin
      data_out <= mem[idx];
    end
  end

endmodule

// File: rtl/class_mem_banked_ctrl.sv
// Banked class memory: round-robin streaming load, then full-row reads with
// one-cycle latency. Define CLASS_MEM_PARITY_EN for per-bank even parity.
module class_mem_banked_ctrl
  import class_mem_pkg::*;
#(
  parameter int FTWIDTH      = FTWIDTH_DEF,
  parameter int NUM_BANKS    = NUM_BANKS_DEF,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int TOTAL_WRITES = TOTAL_WRITES_DEF,
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [FTWIDTH-1:0]             class_in,
  output logic                           write_done,
  input  logic                           re,
  input  logic [ADDR_WIDTH-1:0]          read_address,
  output logic                           rd_valid,
  output logic                           rd_oob,
  output logic [NUM_BANKS*FTWIDTH-1:0]   class_out
`ifdef CLASS_MEM_PARITY_EN
  ,
  output logic [NUM_BANKS-1:0]           parity_err
`endif
);

  localparam int BW        = $clog2(NUM_BANKS);
  localparam int ROWS      = rows_used(TOTAL_WRITES, NUM_BANKS);
  localparam int LAST_ROW  = (TOTAL_WRITES - 1) / NUM_BANKS;
  localparam int LAST_BANK = (TOTAL_WRITES - 1) % NUM_BANKS;
  localparam logic [ADDR_WIDTH:0] ROWS_W = (ADDR_WIDTH + 1)'(ROWS);
`ifdef CLASS_MEM_PARITY_EN
  localparam int BANK_W = FTWIDTH + 1;
`else
  localparam int BANK_W = FTWIDTH;
`endif

  state_t                state_reg;
  logic [BW-1:0]         bank_reg;
  logic [ADDR_WIDTH-1:0] row_reg;
  logic                  blank_reg;

  logic                  accept;
  logic                  last_accept;
  logic                  rd_fire;
  logic                  oob;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] bank_addr;
  logic [BANK_W-1:0]     din;
  logic [BANK_W-1:0]     dout [NUM_BANKS];

  assign in_ready    = (state_reg == LOAD);
  assign write_done  = (state_reg == DONE);
  assign accept      = in_valid & in_ready;
  assign last_accept = (row_reg == ADDR_WIDTH'(LAST_ROW)) && (bank_reg == BW'(LAST_BANK));
  assign rd_fire     = re & (state_reg == DONE);
  assign oob         = ({1'b0, read_address} >= ROWS_W);
  // Out-of-range rows are never presented to the RAM, so the array index stays in bounds.
  assign rd_en       = rd_fire & ~oob;
  assign bank_addr   = (state_reg == LOAD) ? row_reg : read_address;
`ifdef CLASS_MEM_PARITY_EN
  assign din = {^class_in, class_in};
`else
  assign din = class_in;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      bank_reg  <= '0;
      row_reg   <= '0;
      rd_valid  <= 1'b0;
      rd_oob    <= 1'b0;
      blank_reg <= 1'b1;
    end else begin
      rd_valid <= rd_fire;
      if (rd_fire) begin
        rd_oob    <= oob;
        blank_reg <= oob;
      end
      case (state_reg)
        LOAD: begin
          if (accept) begin
            if (last_accept) state_reg <= DONE;
            if (bank_reg == BW'(NUM_BANKS - 1)) begin
              bank_reg <= '0;
              row_reg  <= row_reg + ADDR_WIDTH'(1);
            end else begin
              bank_reg <= bank_reg + BW'(1);
            end
          end
        end
        default: begin
          if (start) begin
            state_reg <= LOAD;
            bank_reg  <= '0;
            row_reg   <= '0;
          end
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    class_mem_bank #(
      .WIDTH      (BANK_W),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank (
      .clk      (clk),
      .we       (accept && (bank_reg == BW'(gi))),
      .en       (rd_en),
      .address  (bank_addr),
      .data_in  (din),
      .data_out (dout[gi])
    );

    assign class_out[gi*FTWIDTH +: FTWIDTH] = blank_reg ? '0 : dout[gi][FTWIDTH-1:0];
`ifdef CLASS_MEM_PARITY_EN
    assign parity_err[gi] = ~blank_reg & (^dout[gi]);
`endif
  end

endmodule
